// File: rtl/feedback_gain_sched.sv
// Closed-loop gain scheduler: acquires lock at a coarse shift, ramps one shift
// step per dwell period to the fine tracking shift, and falls back on loss of lock.
module feedback_gain_sched #(
   parameter int CNT_W = 16,
   parameter int LCK_W = 8
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_trig,
   input  logic signed [31:0] i_err,
   input  logic [31:0]        i_fb_ON,
   input  logic [4:0]         i_gain_start,
   input  logic [4:0]         i_gain_final,
   input  logic [CNT_W-1:0]   i_dwell,
   input  logic [31:0]        i_lock_th,
   input  logic [LCK_W-1:0]   i_lock_cnt,
   output logic [31:0]        o_fb_ON,
   output logic [31:0]        o_gain_sel,
   output logic [2:0]         o_state,
   output logic               o_locked,
   output logic               o_gain_evt,
   output logic               o_lost
);

   typedef enum logic [2:0] {
      ST_OFF   = 3'd0,
      ST_CONST = 3'd1,
      ST_ACQ   = 3'd2,
      ST_RAMP  = 3'd3,
      ST_TRACK = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic [31:0]       fb_q, fb_d;
   logic [4:0]        gain_q, gain_d;
   logic              locked_q, evt_q, lost_q, lost_d;
   logic [LCK_W-1:0]  run_q, run_d;
   logic [CNT_W-1:0]  dwl_q, dwl_d;
   logic [4:0]        sh_start_q, sh_start_d, sh_final_q, sh_final_d;
   logic [CNT_W-1:0]  sh_dwell_q, sh_dwell_d;
   logic [LCK_W-1:0]  sh_lock_q, sh_lock_d;

   logic [31:0]       abs_err;
   logic              in_th;
   logic [LCK_W-1:0]  lock_eff, run_inc, acq_nxt, unl_nxt;
   logic [CNT_W-1:0]  dwell_eff, dwl_inc;
   logic [4:0]        gain_inc;

   // |-2^31| does not fit in 31 bits, so it saturates instead of wrapping
   always_comb begin
      if (!i_err[31])
         abs_err = i_err;
      else if (i_err == 32'sh8000_0000)
         abs_err = 32'h7FFF_FFFF;
      else
         abs_err = -i_err;
   end

   assign in_th     = (abs_err <= i_lock_th);
   assign lock_eff  = (sh_lock_q == '0) ? {{(LCK_W-1){1'b0}}, 1'b1} : sh_lock_q;
   assign dwell_eff = (sh_dwell_q == '0) ? {{(CNT_W-1){1'b0}}, 1'b1} : sh_dwell_q;
   assign run_inc   = run_q + {{(LCK_W-1){1'b0}}, 1'b1};
   assign acq_nxt   = in_th ? run_inc : '0;
   assign unl_nxt   = in_th ? '0 : run_inc;
   assign dwl_inc   = dwl_q + {{(CNT_W-1){1'b0}}, 1'b1};
   assign gain_inc  = gain_q + 5'd1;

   always_comb begin
      state_d    = state_q;
      gain_d     = gain_q;
      run_d      = run_q;
      dwl_d      = dwl_q;
      lost_d     = 1'b0;
      sh_start_d = sh_start_q;
      sh_final_d = sh_final_q;
      sh_dwell_d = sh_dwell_q;
      sh_lock_d  = sh_lock_q;

      if (i_fb_ON != 32'd1 && i_fb_ON != 32'd2) begin
         state_d = ST_OFF;
         gain_d  = i_gain_start;
         run_d   = '0;
         dwl_d   = '0;
      end else if (i_fb_ON == 32'd2) begin
         state_d = ST_CONST;
         gain_d  = i_gain_start;
         run_d   = '0;
         dwl_d   = '0;
      end else begin
         case (state_q)
            ST_OFF, ST_CONST: begin
               state_d    = ST_ACQ;
               gain_d     = i_gain_start;
               run_d      = '0;
               dwl_d      = '0;
               sh_start_d = i_gain_start;
               sh_final_d = i_gain_final;
               sh_dwell_d = i_dwell;
               sh_lock_d  = i_lock_cnt;
            end
            ST_ACQ: begin
               gain_d = sh_start_q;
               if (i_trig) begin
                  if (acq_nxt == lock_eff) begin
                     run_d = '0;
                     dwl_d = '0;
                     if (sh_start_q < sh_final_q) begin
                        state_d = ST_RAMP;
                     end else begin
                        state_d = ST_TRACK;
                        gain_d  = sh_final_q;
                     end
                  end else begin
                     run_d = acq_nxt;
                  end
               end
            end
            ST_RAMP: begin
               if (i_trig) begin
                  if (dwl_inc == dwell_eff) begin
                     dwl_d  = '0;
                     gain_d = gain_inc;
                     if (gain_inc == sh_final_q)
                        state_d = ST_TRACK;
                  end else begin
                     dwl_d = dwl_inc;
                  end
               end
            end
            ST_TRACK: begin
               gain_d = sh_final_q;
               if (i_trig) begin
                  if (unl_nxt == lock_eff) begin
                     state_d = ST_ACQ;
                     gain_d  = sh_start_q;
                     lost_d  = 1'b1;
                     run_d   = '0;
                  end else begin
                     run_d = unl_nxt;
                  end
               end
            end
            default: begin
               state_d = ST_OFF;
               gain_d  = i_gain_start;
               run_d   = '0;
               dwl_d   = '0;
            end
         endcase
      end

      case (state_d)
         ST_OFF:   fb_d = 32'd0;
         ST_CONST: fb_d = 32'd2;
         default:  fb_d = 32'd1;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= ST_OFF;
         fb_q       <= '0;
         gain_q     <= 5'd5;
         locked_q   <= 1'b0;
         evt_q      <= 1'b0;
         lost_q     <= 1'b0;
         run_q      <= '0;
         dwl_q      <= '0;
         sh_start_q <= '0;
         sh_final_q <= '0;
         sh_dwell_q <= '0;
         sh_lock_q  <= '0;
      end else begin
         state_q    <= state_d;
         fb_q       <= fb_d;
         gain_q     <= gain_d;
         locked_q   <= (state_d == ST_TRACK);
         evt_q      <= (gain_d != gain_q);
         lost_q     <= lost_d;
         run_q      <= run_d;
         dwl_q      <= dwl_d;
         sh_start_q <= sh_start_d;
         sh_final_q <= sh_final_d;
         sh_dwell_q <= sh_dwell_d;
         sh_lock_q  <= sh_lock_d;
      end
   end

   assign o_fb_ON    = fb_q;
   assign o_gain_sel = {27'd0, gain_q};
   assign o_state    = state_q;
   assign o_locked   = locked_q;
   assign o_gain_evt = evt_q;
   assign o_lost     = lost_q;

endmodule
